spi_row_reader: RTL and testbench

SPI master that reads one 16-bit word from a 13-bit row address of the external SPI memory and presents it to the avionics logic. It is the read-back counterpart of the row-write path, which drives a 16-bit DATA word and a 13-bit ROW_WRITE address into the same device. It sits between the on-chip control logic and the SPI memory pins and generates SCLK, CS_N and MOSI from the system clock.

---
 rtl/spi_row_reader.sv | 81 ++++++++
 tb/tb_spi_row_reader.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/spi_row_reader.sv
// spi_row_reader: SPI mode-0 master that reads one 16-bit word from a 13-bit row address
module spi_row_reader #(
  parameter int         CLK_DIV  = 4,
  parameter logic [7:0] CMD_READ = 8'h03
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic [12:0] ROW_READ,
  output logic [15:0] DATA_OUT,
  output logic        DATA_VALID,
  output logic        BUSY,
  output logic        SCLK,
  output logic        CS_N,
  output logic        MOSI,
  input  logic        MISO
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;
  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);
  logic [1:0]  state;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [39:0] sr;
  logic [15:0] rx;
  logic        tick;
  assign tick = div_cnt == 8'd0;
  // MOSI comes straight off the shift register MSB; the frame tail is zero so the data phase sends 0
  assign MOSI = sr[39];
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state      <= IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      rx         <= '0;
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
      BUSY       <= 1'b0;
      SCLK       <= 1'b0;
      CS_N       <= 1'b1;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: if (START) begin
          sr      <= {CMD_READ, 3'b000, ROW_READ, 16'h0000};
          CS_N    <= 1'b0;
          BUSY    <= 1'b1;
          div_cnt <= DIV_LD;
          bit_cnt <= '0;
          state   <= SETUP;
        end
        SETUP, SHIFT: if (!tick) div_cnt <= div_cnt - 8'd1;
        else begin
          div_cnt <= DIV_LD;
          if (!SCLK) begin
            SCLK    <= 1'b1;
            bit_cnt <= bit_cnt + 6'd1;
            state   <= SHIFT;
            if (bit_cnt >= 6'd24) rx <= {rx[14:0], MISO};
          end else begin
            SCLK <= 1'b0;
            sr   <= {sr[38:0], 1'b0};
            if (bit_cnt == 6'd40) begin
              state      <= HOLD;
              CS_N       <= 1'b1;
              DATA_OUT   <= rx;
              DATA_VALID <= 1'b1;
            end
          end
        end
        default: if (!tick) div_cnt <= div_cnt - 8'd1;
        else begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_spi_row_reader.sv
// tb_spi_row_reader: table, directed and random reads on CLK_DIV=4 and CLK_DIV=1 instances
module tb_spi_row_reader;
  typedef struct packed {
    int          dv_cnt;
    int          dv_cyc;
    logic [15:0] dv_data;
    int          bf_cnt;
    int          bf_cyc;
    int          cf_cnt;
    int          cf_cyc;
    int          hold_cnt;
    int          fr_cnt;
    int          fr_nr;
    logic [39:0] fr_sh;
  } mon_t;
  typedef struct {
    int          inst;
    logic [12:0] row;
    logic [15:0] data;
    logic [23:0] exp_hdr;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  logic [1:0] start = '0, dv, busy, sclk, cs_n, mosi, miso;
  logic [1:0][12:0] row = '0;
  logic [1:0][15:0] sdata = '0, dout;
  mon_t [1:0] mon;
  int vec = 0, bad = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  for (genvar g = 0; g < 2; g++) begin : u
    int dv_cnt = 0, dv_cyc = 0, bf_cnt = 0, bf_cyc = 0, cf_cnt = 0, cf_cyc = 0;
    int hold_cnt = 0, fr_cnt = 0, fr_nr = 0, nr = 0, idx = 0;
    logic [15:0] dv_data = '0, word = '0;
    logic [39:0] sh = '0, fr_sh = '0;
    logic pb = 1'b0, pc = 1'b1;
    spi_row_reader #(.CLK_DIV(g == 0 ? 4 : 1), .CMD_READ(8'h03)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start[g]), .ROW_READ(row[g]),
      .DATA_OUT(dout[g]), .DATA_VALID(dv[g]), .BUSY(busy[g]), .SCLK(sclk[g]),
      .CS_N(cs_n[g]), .MOSI(mosi[g]), .MISO(miso[g]));
    always @(negedge clk) begin
      if (dv[g] === 1'b1) begin dv_cnt++; dv_cyc = cyc; dv_data = dout[g]; end
      if (pb && busy[g] === 1'b0) begin bf_cnt++; bf_cyc = cyc; end
      if (pc && cs_n[g] === 1'b0) begin cf_cnt++; cf_cyc = cyc; end
      if (cs_n[g] === 1'b1 && busy[g] === 1'b1) hold_cnt++;
      pb = busy[g] === 1'b1;
      pc = cs_n[g] === 1'b1;
    end
    // slave model: word latched at select, bit for rise r presented after the previous fall
    always @(negedge cs_n[g]) word = sdata[g];
    always @(posedge sclk[g] or posedge cs_n[g])
      if (cs_n[g]) begin fr_cnt++; fr_sh = sh; fr_nr = nr; sh = '0; nr = 0; end
      else begin sh = {sh[38:0], mosi[g]}; nr++; end
    always @(negedge sclk[g] or posedge cs_n[g]) idx = cs_n[g] ? 0 : nr;
    assign miso[g] = (idx >= 24 && idx < 40) ? word[4'(39 - idx)] : 1'b0;
    assign mon[g] = {dv_cnt, dv_cyc, dv_data, bf_cnt, bf_cyc, cf_cnt, cf_cyc, hold_cnt, fr_cnt, fr_nr, fr_sh};
  end
  function automatic logic [39:0] exp_frame(input logic [12:0] r);
    return {8'h03, 3'b000, r, 16'h0000};
  endfunction
  function automatic int div_of(input int i);
    return i == 0 ? 4 : 1;
  endfunction
  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
    #1;
  endtask
  task automatic begin_read(input int i, input logic [12:0] r, input logic [15:0] d, output int a, output mon_t b);
    @(negedge clk);
    #1;
    b = mon[i];
    row[i] = r;
    sdata[i] = d;
    start[i] = 1'b1;
    a = cyc + 1;
    @(negedge clk);
    #1;
    start[i] = 1'b0;
  endtask
  task automatic end_read(input int i, input logic [12:0] r, input logic [15:0] d, input int a, input mon_t b);
    int dd = div_of(i);
    int n = 0;
    while (mon[i].bf_cnt == b.bf_cnt && n < 100 * dd + 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("busy_fall_seen", longint'(n < 100 * dd + 50), 1);
    chk("cs_low_cycle", mon[i].cf_cyc, a);
    chk("busy_low_cycle", mon[i].bf_cyc, a + 81 * dd);
    chk("frame_count", mon[i].fr_cnt - b.fr_cnt, 1);
    chk("sclk_rises", mon[i].fr_nr, 40);
    chk("mosi_bits", mon[i].fr_sh, exp_frame(r));
    chk("dv_pulse_cycles", mon[i].dv_cnt - b.dv_cnt, 1);
    chk("dv_cycle", mon[i].dv_cyc, a + 80 * dd);
    chk("dv_data", mon[i].dv_data, d);
    chk("dout_hold", dout[i], d);
    chk("cs_high_busy_cycles", mon[i].hold_cnt - b.hold_cnt, dd);
  endtask
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vec_t tv[4];
    int a, a2;
    mon_t b, b2;
    logic [12:0] r;
    logic [15:0] d;
    tv[0] = '{0, 13'h001D, 16'hA55A, 24'h03001D};
    tv[1] = '{0, 13'h1FFF, 16'hFFFF, 24'h031FFF};
    tv[2] = '{0, 13'h0000, 16'h0000, 24'h030000};
    tv[3] = '{1, 13'h0AAA, 16'h8001, 24'h030AAA};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 2; i++)
        chk("idle_outputs", {cs_n[i], sclk[i], mosi[i], busy[i], dv[i], dout[i]}, {1'b1, 20'h0});
    end
    foreach (tv[k]) begin
      begin_read(tv[k].inst, tv[k].row, tv[k].data, a, b);
      end_read(tv[k].inst, tv[k].row, tv[k].data, a, b);
      chk("header_bits", mon[tv[k].inst].fr_sh[39:16], tv[k].exp_hdr);
    end
    // back-to-back: second START raised mid-frame and held until it is taken
    begin_read(0, 13'h1FFF, 16'hFFFF, a, b);
    wait_to(a + 99);
    start[0] = 1'b1;
    row[0] = 13'h0000;
    sdata[0] = 16'h0000;
    end_read(0, 13'h1FFF, 16'hFFFF, a, b);
    b2 = mon[0];
    a2 = cyc + 1;
    chk("second_accept_cycle", a2, a + 325);
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    end_read(0, 13'h0000, 16'h0000, a2, b2);
    // START pulses while busy are ignored and row changes do not leak into the frame
    r = 13'h1555;
    begin_read(0, r, 16'h3C3C, a, b);
    wait_to(a + 49);
    start[0] = 1'b1;
    row[0] = 13'h0F0F;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    wait_to(a + 199);
    start[0] = 1'b1;
    row[0] = 13'h1234;
    @(negedge clk);
    #1;
    start[0] = 1'b0;
    end_read(0, r, 16'h3C3C, a, b);
    repeat (30) @(negedge clk);
    #1;
    chk("ignored_start_frames", mon[0].cf_cnt - b.cf_cnt, 1);
    // asynchronous reset mid-frame
    begin_read(0, 13'h0123, 16'hBEEF, a, b);
    wait_to(a + 149);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {cs_n[0], sclk[0], mosi[0], busy[0], dv[0], dout[0]}, {1'b1, 20'h0});
    repeat (3) @(negedge clk);
    #1;
    chk("reset_held_outputs", {cs_n[0], sclk[0], mosi[0], busy[0], dv[0], dout[0]}, {1'b1, 20'h0});
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("aborted_frame_dv", mon[0].dv_cnt - b.dv_cnt, 0);
    begin_read(0, 13'h0456, 16'h1234, a, b);
    end_read(0, 13'h0456, 16'h1234, a, b);
    // randomized reads on both divider settings
    for (int k = 0; k < 12; k++) begin
      int i = int'($urandom_range(0, 1));
      r = 13'($urandom);
      d = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      begin_read(i, r, d, a, b);
      end_read(i, r, d, a, b);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
